// File: rtl/ahb_pkg.sv
// Shared AHB encodings used by the data-phase response path.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped space: answers each active transfer with a two-cycle ERROR.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic ahb_clk_in,
  input  logic ahb_rst_in,
  input  logic err_start_in,
  output logic ds_hready_out,
  output logic ds_hresp_out
);

  ds_state_e state_q, state_d;

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ds_hready_out = 1'b1;
    ds_hresp_out  = HRESP_OKAY;
    unique case (state_q)
      DS_IDLE: begin
        if (err_start_in) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        state_d       = DS_ERR2;
        ds_hready_out = 1'b0;
        ds_hresp_out  = HRESP_ERROR;
      end
      DS_ERR2: begin
        // A new unmapped capture on the completing cycle restarts the pair.
        state_d      = err_start_in ? DS_ERR1 : DS_IDLE;
        ds_hresp_out = HRESP_ERROR;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response mux: registers the decoder select and routes the chosen
// slave (or the built-in default slave) back to the master, with a saturating error count.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int unsigned SLAVE_DEVICES  = 2,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                                    ahb_clk_in,
  input  logic                                    ahb_rst_in,
  input  logic [1:0]                              ahb_htrans_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_sel_in,
  input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_hrdata_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hreadyout_in,
  input  logic [SLAVE_DEVICES-1:0]                slave_hresp_in,
  output logic [AHB_DATA_WIDTH-1:0]               ahb_hrdata_out,
  output logic                                    ahb_hready_out,
  output logic                                    ahb_hresp_out,
  output logic [SLAVE_DEVICES:0]                  data_sel_out,
  output logic                                    sel_conflict_out,
  output logic [ERR_CNT_WIDTH-1:0]                err_count_out
);

  logic [SLAVE_DEVICES:0]     data_sel_q, data_sel_d;
  logic                       conflict_q, conflict_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic [SLAVE_DEVICES-1:0]   sel_low;
  logic                       sel_found;
  logic                       err_start;
  logic                       ds_hready, ds_hresp;

  // Lowest-index priority so a malformed multi-hot select still routes deterministically.
  always_comb begin
    sel_low   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (slave_sel_in[i] && !sel_found) begin
        sel_low[i] = 1'b1;
        sel_found  = 1'b1;
      end
    end
  end

  assign err_start = ahb_hready_out && (slave_sel_in == '0) && htrans_active(ahb_htrans_in);

  always_comb begin
    data_sel_d = data_sel_q;
    conflict_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (ahb_hready_out) begin
      conflict_d = ($countones(slave_sel_in) > 1);
      if (slave_sel_in != '0) begin
        data_sel_d = {1'b0, sel_low};
      end else if (htrans_active(ahb_htrans_in)) begin
        data_sel_d = {1'b1, {SLAVE_DEVICES{1'b0}}};
      end else begin
        data_sel_d = '0;
      end
    end
    if (ahb_hready_out && (ahb_hresp_out == HRESP_ERROR) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      data_sel_q <= '0;
      conflict_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      data_sel_q <= data_sel_d;
      conflict_q <= conflict_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  ahb_default_slave u_default_slave (
    .ahb_clk_in    (ahb_clk_in),
    .ahb_rst_in    (ahb_rst_in),
    .err_start_in  (err_start),
    .ds_hready_out (ds_hready),
    .ds_hresp_out  (ds_hresp)
  );

  always_comb begin
    ahb_hrdata_out = '0;
    ahb_hready_out = 1'b1;
    ahb_hresp_out  = HRESP_OKAY;
    for (int i = 0; i < SLAVE_DEVICES; i++) begin
      if (data_sel_q[i]) begin
        ahb_hrdata_out = slave_hrdata_in[i*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
        ahb_hready_out = slave_hreadyout_in[i];
        ahb_hresp_out  = slave_hresp_in[i];
      end
    end
    if (data_sel_q[SLAVE_DEVICES]) begin
      ahb_hready_out = ds_hready;
      ahb_hresp_out  = ds_hresp;
    end
  end

  assign data_sel_out     = data_sel_q;
  assign sel_conflict_out = conflict_q;
  assign err_count_out    = err_cnt_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_ahb_resp_mux;

  localparam int unsigned N  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;
  localparam logic [31:0] D0 = 32'hA5A5_0001;
  localparam logic [31:0] D1 = 32'h5A5A_0002;

  logic            clk;
  logic            rst;
  logic [1:0]      htrans;
  logic [N-1:0]    sel;
  logic [N*W-1:0]  hrdata;
  logic [N-1:0]    rdy;
  logic [N-1:0]    resp;
  logic [W-1:0]    o_hrdata;
  logic            o_hready;
  logic            o_hresp;
  logic [N:0]      o_dsel;
  logic            o_conf;
  logic [CW-1:0]   o_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ahb_resp_mux #(
    .SLAVE_DEVICES  (N),
    .AHB_DATA_WIDTH (W),
    .ERR_CNT_WIDTH  (CW)
  ) dut (
    .ahb_clk_in         (clk),
    .ahb_rst_in         (rst),
    .ahb_htrans_in      (htrans),
    .slave_sel_in       (sel),
    .slave_hrdata_in    (hrdata),
    .slave_hreadyout_in (rdy),
    .slave_hresp_in     (resp),
    .ahb_hrdata_out     (o_hrdata),
    .ahb_hready_out     (o_hready),
    .ahb_hresp_out      (o_hresp),
    .data_sel_out       (o_dsel),
    .sel_conflict_out   (o_conf),
    .err_count_out      (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the data phase (-1 none, 0..N-1 slave, N default slave),
  // which error cycle the default slave is in, and the saturating error total.
  int tgt = -1;
  int phase = 0;
  int cnt = 0;
  bit conf = 0;
  logic [W-1:0] m_hrdata;
  logic         m_hready, m_hresp;
  logic [N:0]   m_dsel;

  task automatic model_eval();
    m_hrdata = '0; m_hready = 1'b1; m_hresp = 1'b0; m_dsel = '0;
    if (tgt >= 0 && tgt < N) begin
      m_hrdata = hrdata[tgt*W +: W];
      m_hready = rdy[tgt];
      m_hresp  = resp[tgt];
      m_dsel   = (N+1)'(1) << tgt;
    end else if (tgt == N) begin
      m_dsel   = (N+1)'(1) << N;
      m_hready = (phase == 2);
      m_hresp  = 1'b1;
    end
  endtask

  task automatic model_step();
    int low;
    if (rst) begin
      tgt = -1; phase = 0; cnt = 0; conf = 0;
    end else begin
      conf = m_hready && ($countones(sel) > 1);
      if (m_hready && m_hresp && cnt < (1 << CW) - 1) cnt++;
      if (!m_hready) begin
        if (tgt == N && phase == 1) phase = 2;
      end else if (sel != '0) begin
        low = -1;
        for (int i = N - 1; i >= 0; i--) if (sel[i]) low = i;
        tgt = low;
      end else if (htrans[1]) begin
        tgt = N; phase = 1;
      end else begin
        tgt = -1;
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic to_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  htrans;
    logic [1:0]  sel;
    logic [1:0]  rdy;
    logic [1:0]  resp;
    logic        e_hready;
    logic        e_hresp;
    logic [31:0] e_hrdata;
    logic [2:0]  e_dsel;
    logic        e_conf;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    vecs[0]  = '{0, 2'b10, 2'b01, 2'b11, 2'b00, 1, 0, 32'h0, 3'b000, 0, 2'd0};
    vecs[1]  = '{0, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, D0,    3'b001, 0, 2'd0};
    vecs[2]  = '{0, 2'b10, 2'b10, 2'b11, 2'b00, 1, 0, 32'h0, 3'b000, 0, 2'd0};
    vecs[3]  = '{0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 0, D1,    3'b010, 0, 2'd0};
    vecs[4]  = '{0, 2'b10, 2'b01, 2'b01, 2'b00, 0, 0, D1,    3'b010, 0, 2'd0};
    vecs[5]  = '{0, 2'b10, 2'b01, 2'b11, 2'b00, 1, 0, D1,    3'b010, 0, 2'd0};
    vecs[6]  = '{0, 2'b10, 2'b00, 2'b11, 2'b00, 1, 0, D0,    3'b001, 0, 2'd0};
    vecs[7]  = '{0, 2'b10, 2'b00, 2'b11, 2'b00, 0, 1, 32'h0, 3'b100, 0, 2'd0};
    vecs[8]  = '{0, 2'b10, 2'b00, 2'b11, 2'b00, 1, 1, 32'h0, 3'b100, 0, 2'd0};
    vecs[9]  = '{0, 2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 32'h0, 3'b100, 0, 2'd1};
    vecs[10] = '{0, 2'b00, 2'b00, 2'b11, 2'b00, 1, 1, 32'h0, 3'b100, 0, 2'd1};
    vecs[11] = '{0, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 32'h0, 3'b000, 0, 2'd2};
    vecs[12] = '{0, 2'b10, 2'b11, 2'b11, 2'b00, 1, 0, 32'h0, 3'b000, 0, 2'd2};
    vecs[13] = '{0, 2'b10, 2'b01, 2'b11, 2'b01, 1, 1, D0,    3'b001, 1, 2'd2};
    vecs[14] = '{0, 2'b10, 2'b01, 2'b11, 2'b01, 1, 1, D0,    3'b001, 0, 2'd3};
    vecs[15] = '{0, 2'b10, 2'b01, 2'b11, 2'b01, 1, 1, D0,    3'b001, 0, 2'd3};
    vecs[16] = '{1, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, D0,    3'b001, 0, 2'd3};
    vecs[17] = '{0, 2'b00, 2'b00, 2'b11, 2'b00, 1, 0, 32'h0, 3'b000, 0, 2'd0};

    // Reset for two cycles with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      htrans = 2'($urandom); sel = N'($urandom); rdy = N'($urandom); resp = N'($urandom);
      hrdata = {$urandom, $urandom};
      to_neg();
      to_edge();
    end

    hrdata = {D1, D0};
    for (int r = 0; r < 18; r++) begin
      rst = vecs[r].rst; htrans = vecs[r].htrans; sel = vecs[r].sel;
      rdy = vecs[r].rdy; resp = vecs[r].resp;
      to_neg();
      chk($sformatf("vec%0d hready", r), 32'(o_hready), 32'(vecs[r].e_hready));
      chk($sformatf("vec%0d hresp", r),  32'(o_hresp),  32'(vecs[r].e_hresp));
      chk($sformatf("vec%0d hrdata", r), o_hrdata,      vecs[r].e_hrdata);
      chk($sformatf("vec%0d data_sel", r), 32'(o_dsel), 32'(vecs[r].e_dsel));
      chk($sformatf("vec%0d conflict", r), 32'(o_conf), 32'(vecs[r].e_conf));
      chk($sformatf("vec%0d err_count", r), 32'(o_cnt), 32'(vecs[r].e_cnt));
      to_edge();
    end

    // Five two-cycle slave ERROR responses: the counter must stop at 3.
    rst = 1'b0; htrans = 2'b10; sel = 2'b01; rdy = 2'b11; resp = 2'b00;
    to_neg();
    to_edge();
    for (int k = 0; k < 5; k++) begin
      rdy = 2'b10; resp = 2'b01;
      to_neg();
      chk($sformatf("slverr%0d wait hready", k), 32'(o_hready), 32'd0);
      chk($sformatf("slverr%0d wait count", k), 32'(o_cnt), (k < 3) ? k : 3);
      to_edge();
      rdy = 2'b11;
      to_neg();
      chk($sformatf("slverr%0d final hresp", k), 32'(o_hresp), 32'd1);
      to_edge();
    end
    resp = 2'b00;
    to_neg();
    chk("slverr saturated count", 32'(o_cnt), 32'd3);
    to_edge();

    // Reset during DS_ERR1 abandons the default-slave response.
    sel = 2'b00; htrans = 2'b11;
    to_neg();
    to_edge();
    to_neg();
    chk("err1 before reset hready", 32'(o_hready), 32'd0);
    rst = 1'b1;
    to_edge();
    rst = 1'b0; htrans = 2'b00;
    to_neg();
    chk("post-reset hready", 32'(o_hready), 32'd1);
    chk("post-reset hresp", 32'(o_hresp), 32'd0);
    chk("post-reset data_sel", 32'(o_dsel), 32'd0);
    chk("post-reset count", 32'(o_cnt), 32'd0);
    to_edge();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 63) == 0);
      htrans = 2'($urandom);
      sel    = ($urandom_range(0, 2) == 0) ? 2'b00 : N'($urandom);
      rdy    = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      resp   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      hrdata = {$urandom, $urandom};
      to_neg();
      chk($sformatf("rnd%0d hready", c), 32'(o_hready), 32'(m_hready));
      chk($sformatf("rnd%0d hresp", c), 32'(o_hresp), 32'(m_hresp));
      chk($sformatf("rnd%0d hrdata", c), o_hrdata, m_hrdata);
      chk($sformatf("rnd%0d data_sel", c), 32'(o_dsel), 32'(m_dsel));
      chk($sformatf("rnd%0d conflict", c), 32'(o_conf), 32'(conf));
      chk($sformatf("rnd%0d err_count", c), 32'(o_cnt), cnt);
      to_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
